// File: rtl/n2r_stream_buffer.sv
// n2r_stream_buffer: buffers B*N input rows and emits them as block-column words
// for N systolic cores; define N2R_DOUBLE_BUFFER_EN for two ping-pong banks.
module n2r_stream_buffer #(
  parameter int WIDTH      = 16,
  parameter int BLOCK_SIZE = 2,
  parameter int NUM_CORES  = 2,
  parameter int COL        = 4,
  parameter int ROW        = 8
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 en,
  input  logic [WIDTH*COL-1:0]                                 in_n2r_buffer,
  input  logic                                                 in_valid,
  output logic                                                 in_ready,
  output logic [WIDTH*BLOCK_SIZE*BLOCK_SIZE*NUM_CORES-1:0]     out_n2r_buffer,
  output logic                                                 out_valid,
  input  logic                                                 out_ready,
  output logic                                                 slice_done,
  output logic                                                 frame_done
);
  localparam int B   = BLOCK_SIZE;
  localparam int N   = NUM_CORES;
  localparam int GR  = B * N;
  localparam int WPG = COL / B;
  localparam int GPF = ROW / GR;
  localparam int OE  = B * B * N;
`ifdef N2R_DOUBLE_BUFFER_EN
  localparam int NB  = 2;
`else
  localparam int NB  = 1;
`endif
  localparam bit DB  = (NB == 2);
  localparam int RW  = $clog2(GR) > 0 ? $clog2(GR) : 1;
  localparam int WW  = $clog2(WPG) > 0 ? $clog2(WPG) : 1;
  localparam int GW  = $clog2(GPF) > 0 ? $clog2(GPF) : 1;

  if (COL % B != 0) begin : g_col_err
    $error("COL must be a multiple of BLOCK_SIZE");
  end
  if (ROW % GR != 0) begin : g_row_err
    $error("ROW must be a multiple of BLOCK_SIZE*NUM_CORES");
  end

  logic [WIDTH*COL-1:0] mem [NB][GR];
  logic [WIDTH*COL-1:0] sel_row [GR];
  logic [NB-1:0]        drain, wr_oh, rd_oh, set_m, clr_m;
  logic                 wr_bank, rd_bank;
  logic [RW-1:0]        row_cnt;
  logic [WW-1:0]        word_cnt;
  logic [GW-1:0]        grp_cnt;
  logic                 in_fire, out_fire, last_row, last_word, last_grp;
  logic [WIDTH*OE-1:0]  word;

  always_comb begin
    wr_oh     = NB'(1) << wr_bank;
    rd_oh     = NB'(1) << rd_bank;
    in_ready  = en && !rst && !(|(drain & wr_oh));
    out_valid = |(drain & rd_oh);
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready;
    last_row  = row_cnt == RW'(GR - 1);
    last_word = word_cnt == WW'(WPG - 1);
    last_grp  = grp_cnt == GW'(GPF - 1);
    set_m     = (in_fire && last_row) ? wr_oh : '0;
    clr_m     = (out_fire && last_word) ? rd_oh : '0;
    out_n2r_buffer = out_valid ? word : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain      <= '0;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      row_cnt    <= '0;
      word_cnt   <= '0;
      grp_cnt    <= '0;
      slice_done <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      drain      <= (drain | set_m) & ~clr_m;
      slice_done <= out_fire && last_word;
      frame_done <= out_fire && last_word && last_grp;
      if (in_fire) begin
        row_cnt <= last_row ? '0 : row_cnt + 1'b1;
        if (last_row) wr_bank <= wr_bank ^ DB;
      end
      if (out_fire) begin
        word_cnt <= last_word ? '0 : word_cnt + 1'b1;
        if (last_word) begin
          rd_bank <= rd_bank ^ DB;
          grp_cnt <= last_grp ? '0 : grp_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) mem[wr_bank][row_cnt] <= in_n2r_buffer;
  end

  for (genvar i = 0; i < GR; i++) begin : g_sel
    assign sel_row[i] = mem[rd_bank][i] << (WIDTH * B * word_cnt);
  end

  for (genvar c = 0; c < N; c++) begin : g_core
    for (genvar r = 0; r < B; r++) begin : g_brow
      for (genvar k = 0; k < B; k++) begin : g_bcol
        assign word[WIDTH*(OE-1-(c*B*B+r*B+k)) +: WIDTH] = sel_row[c*B+r][WIDTH*(COL-1-k) +: WIDTH];
      end
    end
  end
endmodule

// File: tb/tb_n2r_stream_buffer.sv
// tb_n2r_stream_buffer: directed bench for n2r_stream_buffer at WIDTH=16, B=2, N=2, COL=4, ROW=8;
// honours N2R_DOUBLE_BUFFER_EN for the in_ready expectations.
module tb_n2r_stream_buffer;
  localparam int W  = 16;
  localparam int B  = 2;
  localparam int N  = 2;
  localparam int C  = 4;
  localparam int R  = 8;
  localparam int OW = W * B * B * N;
`ifdef N2R_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic          clk = 0, rst = 0, en = 1, in_valid = 0, out_ready = 1;
  logic          in_ready, out_valid, slice_done, frame_done;
  logic [W*C-1:0] din = '0;
  logic [OW-1:0]  dout;
  int            checks = 0, errors = 0, slice_cnt = 0, frame_cnt = 0;

  typedef struct packed {
    logic [OW-1:0] w;
    logic          sl;
    logic          fr;
  } exp_t;
  exp_t q[$];
  exp_t e;
  logic pend_sl = 0, pend_fr = 0;

  always #5 clk = ~clk;

  n2r_stream_buffer #(.WIDTH(W), .BLOCK_SIZE(B), .NUM_CORES(N), .COL(C), .ROW(R)) dut (
    .clk(clk), .rst(rst), .en(en),
    .in_n2r_buffer(din), .in_valid(in_valid), .in_ready(in_ready),
    .out_n2r_buffer(dout), .out_valid(out_valid), .out_ready(out_ready),
    .slice_done(slice_done), .frame_done(frame_done)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W*C-1:0] row_data(input int r);
    logic [W*C-1:0] d;
    for (int k = 0; k < C; k++) d[W*(C-1-k) +: W] = 16'(r * 16 + k);
    return d;
  endfunction

  function automatic logic [OW-1:0] model(input int g, input int j);
    logic [OW-1:0] w;
    for (int c = 0; c < N; c++)
      for (int rr = 0; rr < B; rr++)
        for (int k = 0; k < B; k++)
          w[W*(B*B*N-1-(c*B*B+rr*B+k)) +: W] = 16'((g*B*N + c*B + rr) * 16 + j*B + k);
    return w;
  endfunction

  task automatic push_group(input int g);
    exp_t x;
    for (int j = 0; j < C/B; j++) begin
      x.w  = model(g, j);
      x.sl = (j == C/B - 1);
      x.fr = (j == C/B - 1) && (g == R/(B*N) - 1);
      q.push_back(x);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_row(input int r, output int stalls);
    in_valid = 1;
    din = row_data(r);
    stalls = 0;
    @(negedge clk);
    while (!in_ready && stalls < 50) begin
      stalls++;
      @(negedge clk);
    end
    if (!in_ready) check("in_ready_timeout", in_ready, 1);
    else tick();
    in_valid = 0;
  endtask

  task automatic send_rows(input int first, input int last);
    int s;
    for (int r = first; r <= last; r++) send_row(r, s);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", q.size(), 0);
    tick();
    tick();
  endtask

  always @(negedge clk) begin
    if (rst) begin
      pend_sl = 0;
      pend_fr = 0;
    end else begin
      check("slice_done", slice_done, pend_sl);
      check("frame_done", frame_done, pend_fr);
      slice_cnt += int'(slice_done);
      frame_cnt += int'(frame_done);
      pend_sl = 0;
      pend_fr = 0;
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("extra_word", q.size(), 1);
        else begin
          e = q.pop_front();
          check("word", dout, e.w);
          pend_sl = e.sl;
          pend_fr = e.fr;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s;
    #1 rst = 1;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out", dout, 0);
    check("rst_slice", slice_done, 0);
    check("rst_frame", frame_done, 0);
    tick();
    tick();
    rst = 0;
    tick();
    check("idle_in_ready", in_ready, 1);

    push_group(0);
    send_rows(0, 2);
    check("valid_before_last", out_valid, 0);
    send_rows(3, 3);
    check("valid_latency", out_valid, 1);
    check("first_word", dout, model(0, 0));
    wait_drain();
    check("slice_cnt_g0", slice_cnt, 1);
    check("frame_cnt_g0", frame_cnt, 0);
    push_group(1);
    send_rows(4, 7);
    wait_drain();
    check("slice_cnt_f0", slice_cnt, 2);
    check("frame_cnt_f0", frame_cnt, 1);

    out_ready = 0;
    push_group(0);
    send_rows(0, 3);
    repeat (5) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_word", dout, 128'h0000_0001_0010_0011_0020_0021_0030_0031);
      check("hold_in_ready", in_ready, DB);
    end
    tick();
    out_ready = 1;
    push_group(1);
    send_rows(4, 7);
    wait_drain();
    check("frame_cnt_f1", frame_cnt, 2);

    push_group(0);
    push_group(1);
    for (int r = 0; r < R; r++) begin
      send_row(r, s);
      check("drain_stall", s, (r == 4 && !DB) ? 2 : 0);
    end
    wait_drain();

    out_ready = 0;
    send_rows(0, 3);
    check("pre_rst_valid", out_valid, 1);
    rst = 1;
    #1;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_out", dout, 0);
    check("rst_mid_ready", in_ready, 0);
    tick();
    rst = 0;
    out_ready = 1;
    tick();
    check("post_rst_idle", out_valid, 0);
    send_rows(0, 1);
    check("pre_rst2_ready", in_ready, 1);
    rst = 1;
    #1;
    check("rst2_ready", in_ready, 0);
    check("rst2_valid", out_valid, 0);
    check("rst2_out", dout, 0);
    check("rst2_slice", slice_done, 0);
    check("rst2_frame", frame_done, 0);
    tick();
    rst = 0;
    push_group(0);
    push_group(1);
    send_rows(0, 7);
    wait_drain();

    out_ready = 0;
    push_group(0);
    send_rows(0, 3);
    en = 0;
    out_ready = 1;
    in_valid = 1;
    din = row_data(4);
    repeat (4) begin
      @(negedge clk);
      check("en_low_ready", in_ready, 0);
    end
    in_valid = 0;
    wait_drain();
    en = 1;
    push_group(1);
    send_rows(4, 4);
    en = 0;
    in_valid = 1;
    din = row_data(5);
    repeat (3) begin
      @(negedge clk);
      check("en_low_ready2", in_ready, 0);
    end
    tick();
    en = 1;
    send_rows(5, 7);
    wait_drain();

    check("slice_total", slice_cnt, 10);
    check("frame_total", frame_cnt, 5);
    check("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
